image_loader: RTL and testbench

Write-side counterpart to the VGA image RAM. Accepts a byte stream over a valid/ready handshake, packs every four bytes into one 32-bit word, and drives a single-cycle write port (`we`/`waddr`/`wdata`) that fills the image memory sequentially from address 0. It sits between the host/UART byte source and the image RAM write port, so a new frame can be loaded at run time. It also reports progress and a running checksum.

---
 rtl/image_loader.sv | 107 ++++++++++
 tb/tb_image_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/image_loader.sv
// Byte-stream to 32-bit word packer feeding the image RAM write port.
// Fills WORDS words from address 0 and keeps a running byte checksum.
module image_loader #(
    parameter int WORDS  = 45501,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    // state  | meaning
    // IDLE   | waiting for start after reset
    // LOAD   | accepting bytes, one word write per four bytes
    // DONE   | last word written, waiting for a new start
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

    state_t             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;
    logic [23:0]        pack_q, pack_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        checksum_q, checksum_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        pack_d     = pack_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        checksum_d = checksum_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    checksum_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    pack_d     = {pack_q[15:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    checksum_d = checksum_q + 32'(in_data);
                    // Fourth byte completes the word; older bytes are already in pack_q.
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = {pack_q, in_data};
                        waddr_d    = word_cnt_q;
                        word_cnt_d = word_cnt_q + ADDR_W'(1);
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= '0;
            pack_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            pack_q     <= pack_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            checksum_q <= checksum_d;
        end
    end

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q == S_LOAD);
    assign done     = (state_q == S_DONE);
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with a three-word image: vector table for the
// full-rate load plus hand sequences for reset, bubbles, ignored start and restart.
module tb_image_loader;

    localparam int WORDS  = 3;
    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, we, busy, done;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata, checksum;

    int errors = 0;
    int checks = 0;

    image_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              st;
        logic              vld;
        logic [7:0]        d;
        logic              e_rdy;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [31:0]       e_data;
        logic              e_done;
        logic [31:0]       e_cs;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic vld, input logic [7:0] d);
        start    = st;
        in_valid = vld;
        in_data  = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_we"},       32'(we), 0);
        chk({tag, "_waddr"},    32'(waddr), 0);
        chk({tag, "_wdata"},    wdata, 0);
        chk({tag, "_busy"},     32'(busy), 0);
        chk({tag, "_done"},     32'(done), 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int cyc;
        logic vld;
        logic [31:0] exp_word;

        // Full-rate load vectors: row 0 starts, rows 1..12 carry bytes 1..12.
        tbl[0] = '{st: 1'b1, vld: 1'b0, d: 8'h00, e_rdy: 1'b1, e_we: 1'b0,
                   e_addr: '0, e_data: 32'h0, e_done: 1'b0, e_cs: 32'h0};
        for (int k = 1; k <= 12; k++) begin
            tbl[k].st     = 1'b0;
            tbl[k].vld    = 1'b1;
            tbl[k].d      = 8'(k);
            tbl[k].e_rdy  = (k < 12);
            tbl[k].e_we   = (k % 4 == 0);
            tbl[k].e_addr = ADDR_W'((k - 1) / 4);
            tbl[k].e_data = {8'(k - 3), 8'(k - 2), 8'(k - 1), 8'(k)};
            tbl[k].e_done = (k == 12);
            tbl[k].e_cs   = 32'(k * (k + 1) / 2);
        end
        tbl[13] = '{st: 1'b0, vld: 1'b1, d: 8'hFF, e_rdy: 1'b0, e_we: 1'b0,
                    e_addr: '0, e_data: 32'h0, e_done: 1'b1, e_cs: 32'h4E};
        tbl[14] = '{st: 1'b0, vld: 1'b0, d: 8'h00, e_rdy: 1'b0, e_we: 1'b0,
                    e_addr: '0, e_data: 32'h0, e_done: 1'b1, e_cs: 32'h4E};

        // Reset with in_valid high, then ten quiet cycles.
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h55);
            chk("reset_quiet_we", 32'(we), 0);
            chk("reset_quiet_rdy", 32'(in_ready), 0);
        end

        for (int r = 0; r < 15; r++) begin
            step(tbl[r].st, tbl[r].vld, tbl[r].d);
            chk("tbl_in_ready", 32'(in_ready), 32'(tbl[r].e_rdy));
            chk("tbl_busy",     32'(busy),     32'(tbl[r].e_rdy));
            chk("tbl_we",       32'(we),       32'(tbl[r].e_we));
            chk("tbl_done",     32'(done),     32'(tbl[r].e_done));
            chk("tbl_checksum", checksum,      tbl[r].e_cs);
            if (tbl[r].e_we) begin
                chk("tbl_waddr", 32'(waddr), 32'(tbl[r].e_addr));
                chk("tbl_wdata", wdata, tbl[r].e_data);
            end
        end

        // Reset wins over a simultaneous start, even from DONE.
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        chk_reset_vals("rst_vs_start");
        step(1'b0, 1'b1, 8'h01);
        chk("rst_vs_start_idle", 32'(in_ready), 0);

        // Random bubbles on in_valid.
        step(1'b1, 1'b0, 8'h00);
        idx = 0;
        cyc = 0;
        while (idx < 12 && cyc < 200) begin
            vld = 1'(($urandom_range(0, 1)));
            step(1'b0, vld, 8'(idx + 1));
            if (vld) idx++;
            chk("bubble_we", 32'(we), 32'(vld && (idx % 4 == 0)));
            if (vld && (idx % 4 == 0)) begin
                exp_word = {8'(idx - 3), 8'(idx - 2), 8'(idx - 1), 8'(idx)};
                chk("bubble_waddr", 32'(waddr), 32'(idx / 4 - 1));
                chk("bubble_wdata", wdata, exp_word);
            end
            cyc++;
        end
        chk("bubble_bytes", 32'(idx), 12);
        chk("bubble_checksum", checksum, 32'h4E);
        chk("bubble_done", 32'(done), 1);

        // Restart from DONE, with a start pulse during byte 6 that must be ignored.
        step(1'b1, 1'b0, 8'h00);
        chk("restart_done", 32'(done), 0);
        chk("restart_checksum", checksum, 0);
        chk("restart_ready", 32'(in_ready), 1);
        for (int k = 1; k <= 12; k++) begin
            step(k == 6, 1'b1, 8'(k));
            chk("restart_we", 32'(we), 32'(k % 4 == 0));
            if (k % 4 == 0) begin
                exp_word = {8'(k - 3), 8'(k - 2), 8'(k - 1), 8'(k)};
                chk("restart_waddr", 32'(waddr), 32'(k / 4 - 1));
                chk("restart_wdata", wdata, exp_word);
            end
        end
        chk("restart_final_done", 32'(done), 1);
        chk("restart_final_cs", checksum, 32'h4E);

        // Reset after six bytes discards the partial word.
        step(1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b1, 8'(k));
            if (k == 4) chk("midrst_first_wdata", wdata, 32'h01020304);
        end
        rst = 1'b1;
        step(1'b0, 1'b1, 8'h07);
        rst = 1'b0;
        chk_reset_vals("midrst");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h08);
            chk("midrst_quiet_we", 32'(we), 0);
        end
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hAA);
        step(1'b0, 1'b1, 8'hBB);
        step(1'b0, 1'b1, 8'hCC);
        chk("midrst_we_early", 32'(we), 0);
        step(1'b0, 1'b1, 8'hDD);
        chk("midrst_we", 32'(we), 1);
        chk("midrst_waddr", 32'(waddr), 0);
        chk("midrst_wdata", wdata, 32'hAABBCCDD);
        chk("midrst_checksum", checksum, 32'h30E);
        step(1'b0, 1'b0, 8'h00);
        chk("midrst_we_single", 32'(we), 0);
        chk("midrst_wdata_hold", wdata, 32'hAABBCCDD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
